// File: rtl/reg_file_seq.sv
// 8x8 register file: two registered read ports, one write port, clear sweep.
// Define REG_BYPASS_EN to forward a committing write to a same-address read.
module reg_file_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    input  logic              CLEAR,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;

    // CLEAR wins over a simultaneous write; nothing commits mid-sweep.
    assign we = WRITE && (state == IDLE) && !CLEAR;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            OUT1  <= '0;
            OUT2  <= '0;
            BUSY  <= 1'b0;
            state <= IDLE;
            ptr   <= '0;
        end else begin
            OUT1 <= mem[OUT1ADDRESS];
            OUT2 <= mem[OUT2ADDRESS];
`ifdef REG_BYPASS_EN
            if (we && (OUT1ADDRESS == INADDRESS)) begin
                OUT1 <= IN;
            end
            if (we && (OUT2ADDRESS == INADDRESS)) begin
                OUT2 <= IN;
            end
`endif
            unique case (state)
                IDLE: begin
                    if (CLEAR) begin
                        state <= SWEEP;
                        ptr   <= '0;
                        BUSY  <= 1'b1;
                    end else if (we) begin
                        mem[INADDRESS] <= IN;
                    end
                end
                SWEEP: begin
                    mem[ptr] <= '0;
                    ptr      <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
